// File: rtl/bcd_timer_ctrl_if.sv
// Signal bundle between the MM:SS timer controller and its surroundings
// (debounced buttons, mode switch, the four BCD digit instances).
interface bcd_timer_ctrl_if;
   logic       start_btn;
   logic       clear_btn;
   logic       mode_select;
   logic [3:0] digit0;
   logic [3:0] digit1;
   logic [3:0] digit2;
   logic [3:0] digit3;
   logic       en;
   logic       rst;
   logic [3:0] increase;
   logic [3:0] decrease;
   logic       zero;
   logic       top;
   logic [1:0] state;
   logic       done;

   modport master (
      output start_btn, clear_btn, mode_select, digit0, digit1, digit2, digit3,
      input  en, rst, increase, decrease, zero, top, state, done
   );

   modport slave (
      input  start_btn, clear_btn, mode_select, digit0, digit1, digit2, digit3,
      output en, rst, increase, decrease, zero, top, state, done
   );
endinterface

// File: rtl/bcd_timer_ctrl.sv
// Control side of a 4-digit MM:SS BCD timer: tick prescaler, carry/borrow
// strobe chaining and the IDLE/RUN/PAUSE/DONE start-stop FSM.
module bcd_timer_ctrl #(
   parameter int unsigned TICK_DIV = 100000000,
   parameter int unsigned TICK_W   = 27
) (
   input logic              clk,
   input logic              reset,
   bcd_timer_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      DONE  = 2'b11
   } state_t;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   state_t            state_q, state_d;
   logic [TICK_W-1:0] presc_q, presc_d;
   logic              start_r, clear_r, mode_r;
   logic              start_press, clear_press, mode_change, clear_evt;
   logic              tick, zero_c, top_c, at_end;
   logic              en_q, rst_q, done_q;
   logic [3:0]        inc_q, dec_q, inc_d, dec_d;
   logic [3:0]        carry_up, borrow_dn;

   assign start_press = bus.start_btn & ~start_r;
   assign clear_press = bus.clear_btn & ~clear_r;
   assign mode_change = bus.mode_select ^ mode_r;
   assign clear_evt   = clear_press | mode_change;

   assign zero_c = ~bus.mode_select && bus.digit3 == 4'd0 && bus.digit2 == 4'd0 &&
                   bus.digit1 == 4'd0 && bus.digit0 == 4'd0;
   assign top_c  =  bus.mode_select && bus.digit3 == 4'd5 && bus.digit2 == 4'd9 &&
                   bus.digit1 == 4'd5 && bus.digit0 == 4'd9;
   assign at_end = zero_c | top_c;

   assign tick = (state_q == RUN) && (presc_q == TICK_LAST);

   // Carry/borrow ripple: bit i fires only when every lower digit is at its wrap value.
   assign carry_up[0]  = 1'b1;
   assign carry_up[1]  = bus.digit0 == 4'd9;
   assign carry_up[2]  = carry_up[1] && bus.digit1 == 4'd5;
   assign carry_up[3]  = carry_up[2] && bus.digit2 == 4'd9;
   assign borrow_dn[0] = 1'b1;
   assign borrow_dn[1] = bus.digit0 == 4'd0;
   assign borrow_dn[2] = borrow_dn[1] && bus.digit1 == 4'd0;
   assign borrow_dn[3] = borrow_dn[2] && bus.digit2 == 4'd0;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      inc_d = '0;
      dec_d = '0;
      if (tick && !at_end) begin
         if (bus.mode_select) inc_d = carry_up;
         else                 dec_d = borrow_dn;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clear_evt) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (start_press) state_d = at_end ? DONE : RUN;
            RUN:     if (start_press) state_d = PAUSE;
                     else if (at_end) state_d = DONE;
            PAUSE:   if (start_press) state_d = RUN;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Pausing freezes the prescaler phase, except that a tick already due is consumed.
   always_comb begin
      presc_d = presc_q;
      if (clear_evt || state_d == IDLE || state_d == DONE) begin
         presc_d = '0;
      end else if (state_q == RUN) begin
         if (tick)                  presc_d = '0;
         else if (state_d == RUN)   presc_d = presc_q + TICK_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         presc_q <= '0;
         // Edge detectors load the live inputs so a level held through reset is not a press.
         start_r <= bus.start_btn;
         clear_r <= bus.clear_btn;
         mode_r  <= bus.mode_select;
         en_q    <= 1'b0;
         rst_q   <= 1'b0;
         done_q  <= 1'b0;
         inc_q   <= '0;
         dec_q   <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
         state_q <= state_d;
         presc_q <= presc_d;
         start_r <= bus.start_btn;
         clear_r <= bus.clear_btn;
         mode_r  <= bus.mode_select;
         en_q    <= (state_d == RUN);
         rst_q   <= clear_evt;
         done_q  <= (state_d == DONE);
         inc_q   <= inc_d;
         dec_q   <= dec_d;
      end
   end

   assign bus.en       = en_q;
   assign bus.rst      = rst_q;
   assign bus.done     = done_q;
   assign bus.increase = inc_q;
   assign bus.decrease = dec_q;
   assign bus.zero     = zero_c;
   assign bus.top      = top_c;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_bcd_timer_ctrl.sv
// Directed bench for bcd_timer_ctrl with a 4-cycle tick; digits are driven
// statically by the bench and every expectation is a hand-computed constant.
module tb_bcd_timer_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   bcd_timer_ctrl_if bus ();

   bcd_timer_ctrl #(.TICK_DIV(4), .TICK_W(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_digits(input logic [3:0] d3, input logic [3:0] d2,
                             input logic [3:0] d1, input logic [3:0] d0);
      bus.digit3 = d3;
      bus.digit2 = d2;
      bus.digit1 = d1;
      bus.digit0 = d0;
      #1;
   endtask

   task automatic press_start();
      bus.start_btn = 1'b1;
      step();
      bus.start_btn = 1'b0;
   endtask

   // Steps until any strobe appears; cycles stays 0 if none shows within the bound.
   task automatic next_strobe(output logic [3:0] inc, output logic [3:0] dec, output int cycles);
      inc    = '0;
      dec    = '0;
      cycles = 0;
      for (int i = 1; i <= 20; i++) begin
         if (cycles == 0) begin
            step();
            if ((bus.increase | bus.decrease) != 4'd0) begin
               inc    = bus.increase;
               dec    = bus.decrease;
               cycles = i;
            end
         end
      end
   endtask

   task automatic quiet(input int n, output int hits);
      hits = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if ((bus.increase | bus.decrease) != 4'd0) hits++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [3:0] inc, dec;
      int         cyc, hits;

      reset           = 1'b0;
      bus.start_btn   = 1'b0;
      bus.clear_btn   = 1'b0;
      bus.mode_select = 1'b1;
      set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      step();
      check("rst_state", bus.state, 2'b00);
      check("rst_en", bus.en, 1'b0);
      check("rst_rst", bus.rst, 1'b0);
      check("rst_strobes", {bus.increase, bus.decrease}, 8'h00);
      check("rst_done", bus.done, 1'b0);

      // Up count from 00:00: enter RUN, tick every 4 cycles, strobe one cycle wide
      press_start();
      check("t1_state", bus.state, 2'b01);
      check("t1_en", bus.en, 1'b1);
      quiet(3, hits);
      check("t1_pre_tick", hits, 0);
      step();
      check("t1_inc", bus.increase, 4'b0001);
      check("t1_dec", bus.decrease, 4'b0000);
      step();
      check("t1_width", bus.increase, 4'b0000);
      next_strobe(inc, dec, cyc);
      check("t1_period", cyc, 3);
      check("t1_inc2", inc, 4'b0001);

      // Carry chaining
      set_digits(4'd0, 4'd0, 4'd0, 4'd9);
      next_strobe(inc, dec, cyc);
      check("t2_0009_cyc", cyc, 4);
      check("t2_0009", inc, 4'b0011);
      set_digits(4'd0, 4'd9, 4'd5, 4'd9);
      next_strobe(inc, dec, cyc);
      check("t2_0959", inc, 4'b1111);
      set_digits(4'd0, 4'd1, 4'd5, 4'd8);
      next_strobe(inc, dec, cyc);
      check("t2_0158", inc, 4'b0001);
      set_digits(4'd0, 4'd0, 4'hF, 4'd9);
      next_strobe(inc, dec, cyc);
      check("t2_nonbcd", inc, 4'b0011);
      set_digits(4'd5, 4'd9, 4'd5, 4'd9);
      check("t2_top", bus.top, 1'b1);
      check("t2_zero", bus.zero, 1'b0);
      step();
      check("t2_done_state", bus.state, 2'b11);
      check("t2_done", bus.done, 1'b1);
      check("t2_done_en", bus.en, 1'b0);
      quiet(8, hits);
      check("t2_no_strobe", hits, 0);
      press_start();
      check("t2_done_ignores_start", bus.state, 2'b11);

      // Mode change behaves as clear; then down count with borrows
      set_digits(4'd1, 4'd0, 4'd0, 4'd0);
      bus.mode_select = 1'b0;
      step();
      check("t3_mode_idle", bus.state, 2'b00);
      check("t3_mode_rst", bus.rst, 1'b1);
      check("t3_mode_done", bus.done, 1'b0);
      step();
      check("t3_rst_width", bus.rst, 1'b0);
      press_start();
      check("t3_run", bus.state, 2'b01);
      next_strobe(inc, dec, cyc);
      check("t3_1000_cyc", cyc, 4);
      check("t3_1000_dec", dec, 4'b1111);
      check("t3_1000_inc", inc, 4'b0000);
      set_digits(4'd0, 4'd0, 4'd0, 4'd1);
      next_strobe(inc, dec, cyc);
      check("t3_0001_dec", dec, 4'b0001);
      set_digits(4'd0, 4'd0, 4'd0, 4'd0);
      check("t3_zero", bus.zero, 1'b1);
      step();
      check("t3_done_state", bus.state, 2'b11);
      check("t3_done", bus.done, 1'b1);
      quiet(8, hits);
      check("t3_no_strobe", hits, 0);

      // Pause at prescaler 2, hold for 50 cycles, resume keeps phase
      bus.clear_btn = 1'b1;
      step();
      bus.clear_btn = 1'b0;
      check("t4_clear_idle", bus.state, 2'b00);
      check("t4_clear_rst", bus.rst, 1'b1);
      set_digits(4'd1, 4'd2, 4'd3, 4'd4);
      press_start();
      step();
      step();
      press_start();
      check("t4_pause", bus.state, 2'b10);
      check("t4_pause_en", bus.en, 1'b0);
      hits = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bus.en !== 1'b0 || (bus.increase | bus.decrease) != 4'd0 || bus.state !== 2'b10) hits++;
      end
      check("t4_pause_hold", hits, 0);
      press_start();
      check("t4_resume", bus.state, 2'b01);
      next_strobe(inc, dec, cyc);
      check("t4_resume_phase", cyc, 2);
      check("t4_resume_dec", dec, 4'b0001);

      // Clear and start together in RUN: clear wins
      step();
      bus.clear_btn = 1'b1;
      bus.start_btn = 1'b1;
      step();
      check("t5_both_idle", bus.state, 2'b00);
      check("t5_both_rst", bus.rst, 1'b1);
      check("t5_both_en", bus.en, 1'b0);
      step();
      check("t5_rst_width", bus.rst, 1'b0);
      check("t5_no_toggle", bus.state, 2'b00);
      bus.clear_btn = 1'b0;
      bus.start_btn = 1'b0;
      step();
      press_start();
      next_strobe(inc, dec, cyc);
      check("t5_presc_cleared", cyc, 4);
      press_start();
      check("t5_pause", bus.state, 2'b10);
      bus.mode_select = 1'b1;
      step();
      check("t5_mode_idle", bus.state, 2'b00);
      check("t5_mode_rst", bus.rst, 1'b1);
      step();
      check("t5_mode_rst_width", bus.rst, 1'b0);

      // Async reset between tick and strobe, start held across release
      press_start();
      step();
      step();
      step();
      bus.start_btn = 1'b1;
      reset = 1'b0;
      #1;
      check("t6_async_state", bus.state, 2'b00);
      check("t6_async_outs", {bus.en, bus.rst, bus.done, bus.increase, bus.decrease}, 11'd0);
      #3 reset = 1'b1;
      step();
      check("t6_no_press", bus.state, 2'b00);
      step();
      check("t6_no_strobe", bus.increase, 4'b0000);
      bus.start_btn = 1'b0;
      step();
      press_start();
      check("t6_restart", bus.state, 2'b01);
      next_strobe(inc, dec, cyc);
      check("t6_restart_cyc", cyc, 4);
      check("t6_restart_inc", inc, 4'b0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bcd_timer_ctrl.md
Name: bcd_timer_ctrl

Overview:
- Control side of the per-digit BCD counter: drives `en`, `increase`/`decrease`, `rst`, `zero` and `top` for a 4-digit MM:SS chain of BCD counter digits.
- Reads the digits back, generates the 1 Hz tick and carry/borrow chaining, and runs a start/pause/clear/done FSM.
- Sits between debounced pushbuttons and the four digit instances.

Parameters:
TICK_DIV, 100000000, clk cycles per count tick (1 Hz at 100 MHz); minimum 2
TICK_W, 27, prescaler width; must hold TICK_DIV-1

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
start_btn  input  1  debounced level, start/pause toggle
clear_btn  input  1  debounced level, clear request
mode_select  input  1  0 = down count, 1 = up count; passed unchanged to digits
digit0  input  4  seconds ones, read back from counter
digit1  input  4  seconds tens
digit2  input  4  minutes ones
digit3  input  4  minutes tens
en  output  1  counter enable
rst  output  1  synchronous reload pulse to all digits
increase  output  4  per-digit up-count strobe, bit i drives digit i
decrease  output  4  per-digit down-count strobe
zero  output  1  down mode and all digits 0
top  output  1  up mode and digits = 5,9,5,9 (59:59)
state  output  2  00 IDLE, 01 RUN, 10 PAUSE, 11 DONE
done  output  1  high in DONE

Behaviour:
- Reset (reset=0, async) clears all registers:
  - state=IDLE, en=0, rst=0, increase=0, decrease=0, done=0, prescaler=0.
  - Edge-detect registers take the current button value, so a button held through reset generates no press.
- Button edges:
  - start_btn and clear_btn are registered once.
  - A press is a 0->1 transition; it lasts one cycle and is acted on in the same cycle it is detected.
- mode change:
  - mode_select is registered once.
  - Any change of the registered value is treated exactly like a clear press.
- `zero` and `top` are combinational from the digit inputs and mode_select.
- FSM transitions, in priority order:
  1. Clear press or mode change, from any state -> IDLE. `rst`=1 for exactly that one cycle; prescaler cleared.
  2. IDLE + start press -> RUN, or -> DONE if zero/top is already high.
  3. RUN + start press -> PAUSE.
  4. RUN + (zero|top) -> DONE.
  5. PAUSE + start press -> RUN.
  6. DONE ignores start presses.
- Clear and start pressed in the same cycle: clear wins; the start press is discarded.
- Prescaler:
  - Counts only in RUN, 0..TICK_DIV-1, then wraps to 0.
  - `tick`=1 for one cycle when prescaler = TICK_DIV-1 in RUN.
  - PAUSE holds the prescaler value, so resume keeps tick phase.
  - IDLE and DONE hold it at 0.
- en = (state==RUN), registered.
- Strobe generation:
  - All strobes are 0 when tick=0, when zero/top is high, or when not in RUN.
  - Up mode:
    - increase[0]=tick
    - increase[1]=tick & d0==9
    - increase[2]=tick & d0==9 & d1==5
    - increase[3]=tick & d0==9 & d1==5 & d2==9
  - Down mode:
    - decrease[0]=tick
    - decrease[1]=tick & d0==0
    - decrease[2]=tick & d0==0 & d1==0
    - decrease[3]=tick & d0==0 & d1==0 & d2==0
  - The strobe lines of the inactive direction are held at 0.
- Strobes are registered: they are asserted one cycle after the tick and are one cycle wide. Digits update on the following edge.
- Digit wrap (9->0, 5->0, 0->reload) is done by the digit instances; this block only gates the strobes.
- Reaching 59:59 (up) or 00:00 (down) causes RUN->DONE on the cycle the comparison goes true. No further strobes are issued.
- All digit compares are exact 4-bit equality. Non-BCD digit values (10-15) are not 9, 5 or 0, so they generate no carry or borrow.
- done=1 exactly in DONE; it is cleared only by a clear press, a mode change or reset.

Test Plan:
1. TICK_DIV=4, up mode, IDLE, digits 00:00, start press -> RUN next cycle, en=1. Tick every 4 cycles. increase=0001 one cycle wide, one cycle after each tick.
2. Up mode, digits 00:09 or 09:59, tick -> increase=0011 or 1111 respectively. A tick at 01:58 -> increase=0001 only.
3. Down mode, digits 10:00, tick -> decrease=1111. Digits 00:01, tick -> decrease=0001. When the digits reach 00:00 -> zero=1, state=DONE, done=1, no further strobes.
4. RUN with prescaler=2, start press -> PAUSE, en=0 for 50 cycles. Resume -> first tick arrives after exactly 1 further RUN cycle.
5. Clear and start pressed in the same cycle while in RUN -> IDLE, rst=1 for exactly one cycle, prescaler=0, no state toggle. Toggling mode_select in PAUSE -> same response.
6. Assert reset mid-RUN between tick and strobe -> all outputs 0, state=IDLE immediately. start_btn held high across the reset release -> no press detected.
